microbot_motor_pwm: RTL



---
 rtl/microbot_pkg.sv | 20 ++
 rtl/microbot_motor_channel.sv | 97 +++++++++
 rtl/microbot_motor_pwm.sv | 81 ++++++++
 3 files changed

// File: rtl/microbot_pkg.sv
// rtl/microbot_pkg.sv - shared channel state and command encodings for the motor PWM stage
package microbot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DEAD  = 2'd2,
        BRAKE = 2'd3
    } chan_state_e;

    localparam logic [1:0] CMD_COAST = 2'b00;
    localparam logic [1:0] CMD_REV   = 2'b01;
    localparam logic [1:0] CMD_FWD   = 2'b10;
    localparam logic [1:0] CMD_BRAKE = 2'b11;

    function automatic logic is_drive_cmd(input logic [1:0] cmd);
        return (cmd == CMD_FWD) || (cmd == CMD_REV);
    endfunction

endpackage

// File: rtl/microbot_motor_channel.sv
// rtl/microbot_motor_channel.sv - per-motor bridge FSM with dead time between drive/brake phases
module microbot_motor_channel
    import microbot_pkg::*;
#(
    parameter int DEAD_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cmd,
    input  logic       pwm_on,
    output logic       in1,
    output logic       in2,
    output logic       busy
);

    localparam int DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_TICKS - 1);

    chan_state_e       state_q, state_d;
    logic              dir_fwd_q, dir_fwd_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            dir_fwd_q  <= 1'b0;
            dead_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dir_fwd_q  <= dir_fwd_d;
            dead_cnt_q <= dead_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_fwd_d  = dir_fwd_q;
        dead_cnt_d = dead_cnt_q;
        case (state_q)
            IDLE: begin
                if (is_drive_cmd(cmd)) begin
                    state_d   = DRIVE;
                    dir_fwd_d = (cmd == CMD_FWD);
                end else if (cmd == CMD_BRAKE) begin
                    state_d = BRAKE;
                end
            end
            DRIVE: begin
                if (cmd != (dir_fwd_q ? CMD_FWD : CMD_REV)) begin
                    state_d    = DEAD;
                    dead_cnt_d = DEAD_LOAD;
                end
            end
            BRAKE: begin
                if (cmd != CMD_BRAKE) begin
                    state_d    = DEAD;
                    dead_cnt_d = DEAD_LOAD;
                end
            end
            DEAD: begin
                // Only the command present at expiry matters; anything earlier is ignored.
                if (dead_cnt_q == '0) begin
                    if (is_drive_cmd(cmd)) begin
                        state_d   = DRIVE;
                        dir_fwd_d = (cmd == CMD_FWD);
                    end else if (cmd == CMD_BRAKE) begin
                        state_d = BRAKE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    dead_cnt_d = dead_cnt_q - DEAD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in1  = 1'b0;
        in2  = 1'b0;
        busy = 1'b0;
        case (state_q)
            DRIVE: begin
                in1 = dir_fwd_q & pwm_on;
                in2 = ~dir_fwd_q & pwm_on;
            end
            BRAKE: begin
                in1 = 1'b1;
                in2 = 1'b1;
            end
            DEAD:    busy = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/microbot_motor_pwm.sv
// rtl/microbot_motor_pwm.sv - shared PWM timebase and duty shadow driving two motor bridge channels
module microbot_motor_pwm
    import microbot_pkg::*;
#(
    parameter int PRESCALE   = 4,
    parameter int DUTY_W     = 5,
    parameter int DEAD_TICKS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              cmd_a_d,
    input  logic              cmd_a_i,
    input  logic              cmd_b_d,
    input  logic              cmd_b_i,
    output logic              a_in1,
    output logic              a_in2,
    output logic              b_in1,
    output logic              b_in2,
    output logic              a_busy,
    output logic              b_busy,
    output logic              pwm_sync
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DUTY_W-1:0] duty_act_q, duty_act_d;
    logic              tick;
    logic              pwm_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
            duty_act_q <= '0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            duty_act_q <= duty_act_d;
        end
    end

    always_comb begin
        tick       = (pre_cnt_q == PRE_LAST);
        pre_cnt_d  = tick ? '0 : pre_cnt_q + PRE_W'(1);
        pwm_cnt_d  = tick ? pwm_cnt_q + DUTY_W'(1) : pwm_cnt_q;
        // Duty is shadowed so a period never mixes two duty values.
        duty_act_d = (tick && (pwm_cnt_q == '1)) ? duty_in : duty_act_q;
    end

    assign pwm_on   = (pwm_cnt_q < duty_act_q);
    assign pwm_sync = ~reset && (pre_cnt_q == '0) && (pwm_cnt_q == '0);

    microbot_motor_channel #(
        .DEAD_TICKS(DEAD_TICKS)
    ) u_chan_a (
        .clk    (clk),
        .reset  (reset),
        .cmd    ({cmd_a_d, cmd_a_i}),
        .pwm_on (pwm_on),
        .in1    (a_in1),
        .in2    (a_in2),
        .busy   (a_busy)
    );

    microbot_motor_channel #(
        .DEAD_TICKS(DEAD_TICKS)
    ) u_chan_b (
        .clk    (clk),
        .reset  (reset),
        .cmd    ({cmd_b_d, cmd_b_i}),
        .pwm_on (pwm_on),
        .in1    (b_in1),
        .in2    (b_in2),
        .busy   (b_busy)
    );

endmodule
